// File: rtl/bit_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_stream_serializer
// Purpose  : Parallel-to-serial front end for serial sequence detectors.
//            Accepts WORD_W-bit words on a valid/ready handshake and shifts
//            them out one bit per clock. An optional forced idle gap can
//            follow each word. The idle level of the line is programmable.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1       rising-edge clock
//   rst_n          in   1       asynchronous active-low reset
//   i_word_in      in   WORD_W  parallel word, captured on the accept edge
//   i_word_valid   in   1       i_word_in holds a word to send
//   o_word_ready   out  1       a word can be accepted this cycle (comb)
//   o_bit_out      out  1       serial bit stream (registered)
//   o_bit_valid    out  1       o_bit_out carries a data bit (registered)
//   o_last_bit     out  1       current bit is the last of its word (reg)
//   o_busy         out  1       FSM is not in IDLE
//   o_words_sent   out  16      completed-word count, wraps at 0xFFFF
// ============================================================================
module bit_stream_serializer #(
  parameter int WORD_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] i_word_in,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_bit_out,
  output logic              o_bit_valid,
  output logic              o_last_bit,
  output logic              o_busy,
  output logic [15:0]       o_words_sent
);

  localparam int              CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);
  // The gap counter counts down to zero, so it is loaded with GAP_CYCLES-1.
  localparam logic [7:0]      GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [WORD_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [7:0]        r_gap_cnt;
  logic              r_bit;
  logic              r_bit_valid;
  logic              r_last;
  logic [15:0]       r_words_sent;

  logic              w_accept;
  logic              w_word_end;
  logic              w_first_bit;
  logic              w_next_bit;
  logic [WORD_W-1:0] w_load_shift;
  logic [WORD_W-1:0] w_shift_nxt;

  // The shift register holds the bits not yet presented, with the next one
  // at the head (MSB for MSB-first, LSB for LSB-first).
  assign w_first_bit  = MSB_FIRST ? i_word_in[WORD_W-1] : i_word_in[0];
  assign w_next_bit   = MSB_FIRST ? r_shift[WORD_W-1]   : r_shift[0];
  assign w_load_shift = MSB_FIRST ? (i_word_in << 1)    : (i_word_in >> 1);
  assign w_shift_nxt  = MSB_FIRST ? (r_shift << 1)      : (r_shift >> 1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_last) begin
          if (GAP_CYCLES > 0) begin
            w_state_nxt = S_GAP;
          end else if (w_accept) begin
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / handshake logic
  always_comb begin
    o_word_ready = 1'b0;
    o_busy       = (r_state != S_IDLE);
    w_word_end   = (r_state == S_SHIFT) && r_last;
    // Back-to-back streaming: a new word may be taken on the edge that ends
    // the last bit, but only when no idle gap has to be inserted.
    if (r_state == S_IDLE) begin
      o_word_ready = 1'b1;
    end else if ((r_state == S_SHIFT) && r_last && (GAP_CYCLES == 0)) begin
      o_word_ready = 1'b1;
    end
    w_accept = i_word_valid && o_word_ready;
  end

  // Datapath: shift register, bit counter, gap counter, registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_bit        <= IDLE_LEVEL;
      r_bit_valid  <= 1'b0;
      r_last       <= 1'b0;
      r_words_sent <= '0;
    end else begin
      if (w_accept) begin
        r_shift     <= w_load_shift;
        r_bit       <= w_first_bit;
        r_bit_valid <= 1'b1;
        r_bit_cnt   <= '0;
        r_last      <= 1'b0;
      end else if ((r_state == S_SHIFT) && !r_last) begin
        r_shift     <= w_shift_nxt;
        r_bit       <= w_next_bit;
        r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
        r_last      <= ((r_bit_cnt + CNT_W'(1)) == LAST_IDX);
      end else if (w_word_end) begin
        // Word finished with nothing to follow: return the line to idle.
        r_bit       <= IDLE_LEVEL;
        r_bit_valid <= 1'b0;
        r_bit_cnt   <= '0;
        r_last      <= 1'b0;
      end

      if (w_word_end) begin
        r_words_sent <= r_words_sent + 16'd1;
      end

      if (w_word_end && (GAP_CYCLES > 0)) begin
        r_gap_cnt <= GAP_LOAD;
      end else if ((r_state == S_GAP) && (r_gap_cnt != 8'd0)) begin
        r_gap_cnt <= r_gap_cnt - 8'd1;
      end
    end
  end

  assign o_bit_out    = r_bit;
  assign o_bit_valid  = r_bit_valid;
  assign o_last_bit   = r_last;
  assign o_words_sent = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_bit_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_stream_serializer
// Purpose  : Self-checking bench for bit_stream_serializer. Three instances
//            cover MSB-first/no gap, MSB-first/2-cycle gap with idle level 1,
//            and LSB-first/no gap. Expected values come from a word-level
//            model: accepted word -> WORD_W bits in order, then the gap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_stream_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  wi [3];
  logic [2:0]  wv;
  logic [2:0]  wr, ob, obv, ol, obusy;
  logic [15:0] ws [3];

  // Per-instance configuration as seen by the model.
  localparam bit [2:0] IDLE_L = 3'b010;
  localparam bit [2:0] MSB_F  = 3'b011;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_ws [3];

  always #5 clk = ~clk;

  bit_stream_serializer #(.WORD_W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .i_word_in(wi[0]), .i_word_valid(wv[0]),
    .o_word_ready(wr[0]), .o_bit_out(ob[0]), .o_bit_valid(obv[0]),
    .o_last_bit(ol[0]), .o_busy(obusy[0]), .o_words_sent(ws[0]));

  bit_stream_serializer #(.WORD_W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .i_word_in(wi[1]), .i_word_valid(wv[1]),
    .o_word_ready(wr[1]), .o_bit_out(ob[1]), .o_bit_valid(obv[1]),
    .o_last_bit(ol[1]), .o_busy(obusy[1]), .o_words_sent(ws[1]));

  bit_stream_serializer #(.WORD_W(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .i_word_in(wi[2]), .i_word_valid(wv[2]),
    .o_word_ready(wr[2]), .o_bit_out(ob[2]), .o_bit_valid(obv[2]),
    .o_last_bit(ol[2]), .o_busy(obusy[2]), .o_words_sent(ws[2]));

  function automatic int gap_of(input int idx);
    return (idx == 1) ? 2 : 0;
  endfunction

  // Bit k of the serial stream for a word, from the bit-order rule alone.
  function automatic logic exp_bit(input logic [7:0] w, input int k, input bit msb);
    return msb ? w[7-k] : w[k];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int idx);
    chk("rst_ready", 32'(wr[idx]),    32'd1);
    chk("rst_valid", 32'(obv[idx]),   32'd0);
    chk("rst_bit",   32'(ob[idx]),    32'(IDLE_L[idx]));
    chk("rst_last",  32'(ol[idx]),    32'd0);
    chk("rst_busy",  32'(obusy[idx]), 32'd0);
    chk("rst_ws",    32'(ws[idx]),    32'd0);
  endtask

  // Sends n words into instance idx (first two fixed, rest random), checking
  // every cycle of bits and gap against the word-level model.
  task automatic run_words(input int idx, input int n, input logic [7:0] w0, input logic [7:0] w1);
    int         gap;
    logic [7:0] w;
    gap = gap_of(idx);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : (i == 1) ? w1 : 8'($urandom);
      wi[idx] = w;
      wv[idx] = 1'b1;
      chk("ready_accept", 32'(wr[idx]), 32'd1);
      tick();
      for (int k = 0; k < 8; k++) begin
        chk("bit_valid", 32'(obv[idx]),   32'd1);
        chk("bit_out",   32'(ob[idx]),    32'(exp_bit(w, k, MSB_F[idx])));
        chk("last_bit",  32'(ol[idx]),    32'(k == 7));
        chk("busy",      32'(obusy[idx]), 32'd1);
        if (k == 0) chk("words_sent_mid", 32'(ws[idx]), 32'(exp_ws[idx]));
        if (k < 7) begin
          // Junk on the inputs while not ready must be ignored.
          wv[idx] = 1'($urandom);
          wi[idx] = 8'($urandom);
          chk("ready_busy", 32'(wr[idx]), 32'd0);
          tick();
        end
      end
      exp_ws[idx] = exp_ws[idx] + 16'd1;
      if (gap == 0 && i < n - 1) continue;
      wv[idx] = (i < n - 1);
      wi[idx] = 8'($urandom);
      chk("ready_last", 32'(wr[idx]), 32'(gap == 0));
      tick();
      for (int g = 0; g < gap; g++) begin
        chk("gap_valid", 32'(obv[idx]),   32'd0);
        chk("gap_bit",   32'(ob[idx]),    32'(IDLE_L[idx]));
        chk("gap_ready", 32'(wr[idx]),    32'd0);
        chk("gap_busy",  32'(obusy[idx]), 32'd1);
        if (g == 0) chk("gap_ws", 32'(ws[idx]), 32'(exp_ws[idx]));
        tick();
      end
    end
    chk("end_valid", 32'(obv[idx]),   32'd0);
    chk("end_bit",   32'(ob[idx]),    32'(IDLE_L[idx]));
    chk("end_busy",  32'(obusy[idx]), 32'd0);
    chk("end_ready", 32'(wr[idx]),    32'd1);
    chk("end_ws",    32'(ws[idx]),    32'(exp_ws[idx]));
  endtask

  initial begin
    logic [7:0] c3;
    c3 = 8'hC3;
    rst_n = 1'b0;
    wv    = 3'b111;
    for (int j = 0; j < 3; j++) begin
      wi[j]     = 8'($urandom);
      exp_ws[j] = 16'd0;
    end

    // Reset held with word_valid asserted.
    tick();
    tick();
    for (int j = 0; j < 3; j++) chk_reset(j);
    wv = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset mid-word: three bits of 8'hC3, then reset during the fourth.
    wi[0] = c3;
    wv[0] = 1'b1;
    tick();
    wv[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("pre_rst_bit", 32'(ob[0]), 32'(exp_bit(c3, k, 1'b1)));
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single MSB-first word, then back-to-back FF/00 plus a random word.
    run_words(0, 1, 8'hA5, 8'h00);
    run_words(0, 3, 8'hFF, 8'h00);

    // Two-cycle gap with an idle level of 1.
    run_words(1, 3, 8'($urandom), 8'($urandom));

    // LSB first, then counter wrap.
    run_words(2, 2, 8'h01, 8'($urandom));
    force u_d2.r_words_sent = 16'hFFFF;
    tick();
    release u_d2.r_words_sent;
    tick();
    exp_ws[2] = 16'hFFFF;
    chk("ws_preload", 32'(ws[2]), 32'(exp_ws[2]));
    run_words(2, 1, 8'($urandom), 8'h00);
    chk("ws_wrapped", 32'(ws[2]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
